// File: rtl/bcd_display_driver.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle) driving
// eight active-low 7-segment digits. Define BCD_DISPLAY_BLANK_EN to blank leading zeros.
module bcd_display_driver #(
  parameter int IN_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [IN_WIDTH-1:0] value,
  output logic                ready,
  output logic                done,
  output logic [6:0]          HEX0,
  output logic [6:0]          HEX1,
  output logic [6:0]          HEX2,
  output logic [6:0]          HEX3,
  output logic [6:0]          HEX4,
  output logic [6:0]          HEX5,
  output logic [6:0]          HEX6,
  output logic [6:0]          HEX7
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  localparam int              CNT_W       = $clog2(IN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(IN_WIDTH - 1);
  localparam logic [63:0]     MAX_DISPLAY = 64'd99_999_999;
  localparam logic [6:0]      GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0]      GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0]      GLYPH_ZERO  = 7'b1000000;

  logic [1:0]          state;
  logic [IN_WIDTH-1:0] bin;
  logic [31:0]         bcd;
  logic [31:0]         bcd_adj;
  logic [CNT_W-1:0]    cnt;
  logic                ovf;
  logic [63:0]         value_ext;
  logic [6:0]          hex_next [8];
  logic [6:0]          hex_q    [8];

  function automatic logic [6:0] glyph(input logic [3:0] digit);
    case (digit)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = GLYPH_DASH;
    endcase
  endfunction

  // Glyph shown on digit i after reset, i.e. the display of the value 0.
  function automatic logic [6:0] reset_glyph(input int i);
`ifdef BCD_DISPLAY_BLANK_EN
    reset_glyph = (i == 0) ? GLYPH_ZERO : GLYPH_BLANK;
`else
    reset_glyph = (i >= 0) ? GLYPH_ZERO : GLYPH_BLANK;
`endif
  endfunction

  assign value_ext = 64'(value);
  assign ready     = (state == IDLE);

  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 8; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
`ifdef BCD_DISPLAY_BLANK_EN
    logic leading;
    leading = 1'b1;
`endif
    for (int i = 7; i >= 0; i--) begin
      hex_next[i] = glyph(bcd[4*i +: 4]);
`ifdef BCD_DISPLAY_BLANK_EN
      if (bcd[4*i +: 4] != 4'd0) leading = 1'b0;
      if (leading && i != 0) hex_next[i] = GLYPH_BLANK;
`endif
      if (ovf) hex_next[i] = GLYPH_DASH;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < 8; i++) hex_q[i] <= reset_glyph(i);
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            bin   <= value;
            ovf   <= (value_ext > MAX_DISPLAY);
            bcd   <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd <= {bcd_adj[30:0], bin[IN_WIDTH-1]};
          bin <= {bin[IN_WIDTH-2:0], 1'b0};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_SHIFT) state <= UPDATE;
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) hex_q[i] <= hex_next[i];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_bcd_display_driver.sv
// Scoreboard bench for bcd_display_driver: stimulus pushes expected displays and
// done times, a negedge monitor pops on each done pulse and checks held displays.
module tb_bcd_display_driver;

  localparam int         W   = 32;
  localparam int         LAT = W + 1;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef struct packed {
    logic [7:0][6:0] hex;
    logic [31:0]     due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] value;
  logic         ready;
  logic         done;
  logic [6:0]   HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic [7:0][6:0] hex_bus;

  exp_t            q[$];
  exp_t            mon_e;
  logic [7:0][6:0] cur;
  logic [7:0][6:0] reset_hex;
  logic [6:0]      glyph_tab [10];
  bit              mon_en = 1'b0;
  int              checks = 0;
  int              failures = 0;
  int              cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_display_driver #(.IN_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .ready(ready), .done(done),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
  );

  assign hex_bus = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal reference model built from division, independent of double-dabble.
  function automatic logic [7:0][6:0] model(input logic [31:0] v);
    logic [7:0][6:0] r;
    longint unsigned t;
    longint unsigned pow;
    t = v;
    pow = 1;
    for (int i = 0; i < 8; i++) begin
      r[i] = glyph_tab[t % 10];
      t = t / 10;
`ifdef BCD_DISPLAY_BLANK_EN
      if (i != 0 && longint'(v) < pow) r[i] = BLANK;
`endif
      pow = pow * 10;
    end
    if (v > 32'd99_999_999) r = {8{DASH}};
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          mon_e = q.pop_front();
          check("done_latency", 64'(cyc), 64'(mon_e.due));
          check("hex_result", 64'(hex_bus), 64'(mon_e.hex));
          check("ready_after_done", 64'(ready), 64'd1);
          cur = mon_e.hex;
        end
      end else begin
        if (q.size() != 0 && cyc > int'(q[0].due)) begin
          check("done_missing", 64'(done), 64'd1);
          void'(q.pop_front());
        end
        check("hex_hold", 64'(hex_bus), 64'(cur));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    cur    = reset_hex;
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input logic [31:0] v);
    @(negedge clk);
    load  = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    q.push_back(exp_t'{hex: model(v), due: 32'(cyc + LAT)});
    check("ready_busy", 64'(ready), 64'd0);
    @(negedge clk);
    load  = 1'b0;
    value = $urandom();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < LAT + 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      check("done_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
`ifdef BCD_DISPLAY_BLANK_EN
    reset_hex = {{7{BLANK}}, 7'b1000000};
`else
    reset_hex = {8{7'b1000000}};
`endif
    rst   = 1'b0;
    load  = 1'b0;
    value = '0;

    do_reset();
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hex", 64'(hex_bus), 64'(reset_hex));

    foreach (glyph_tab[k]) begin end
    begin
      logic [31:0] vecs [8];
      vecs = '{32'd12345, 32'd99_999_999, 32'd100_000_000, 32'd0,
               32'd87_654_321, 32'hFFFF_FFFF, 32'd10, 32'd1_000_000};
      foreach (vecs[k]) begin
        issue(vecs[k]);
        wait_idle();
      end
    end

    // A load while busy must be ignored; only the 42 completes.
    issue(32'd42);
    repeat (4) @(negedge clk);
    load  = 1'b1;
    value = 32'd7;
    @(posedge clk);
    #1;
    check("ready_ignored_load", 64'(ready), 64'd0);
    @(negedge clk);
    load = 1'b0;
    wait_idle();
    repeat (LAT + 5) @(negedge clk);

    // Reset mid-conversion aborts with no done pulse.
    issue(32'd555);
    repeat (9) @(negedge clk);
    do_reset();
    check("ready_after_abort", 64'(ready), 64'd1);
    check("hex_after_abort", 64'(hex_bus), 64'(reset_hex));
    repeat (LAT + 5) @(negedge clk);

    // Reset wins over a simultaneous load.
    @(negedge clk);
    rst   = 1'b1;
    load  = 1'b1;
    value = 32'd321;
    @(posedge clk);
    #1;
    q.delete();
    cur = reset_hex;
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    check("ready_rst_load", 64'(ready), 64'd1);
    repeat (LAT + 5) @(negedge clk);

    issue(32'd2_024);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_display_driver.md
BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32: bit width of the value input.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port load, input, 1 bit: request to convert and display value.
REQ-005 SHALL have port value, input, IN_WIDTH bits: unsigned binary number from the CPU I/O register.
REQ-006 SHALL have port ready, output, 1 bit: high when a load will be accepted.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when the HEX outputs update.
REQ-008 SHALL have ports HEX0..HEX7, output, 7 bits each: active-low segments {g,f,e,d,c,b,a}; HEX0 is the least significant decimal digit.

Function
REQ-009 SHALL implement FSM states IDLE, SHIFT and UPDATE.
REQ-010 In IDLE, ready SHALL be 1; at an edge with load=1 the block SHALL capture value, clear the 32-bit BCD accumulator, zero the bit counter and enter SHIFT.
REQ-011 In SHIFT, each cycle SHALL first add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1 (double-dabble), one input bit per cycle, for exactly IN_WIDTH cycles.
REQ-012 UPDATE SHALL last 1 cycle; it SHALL register all eight HEX outputs, drive done=1 for that cycle only, and return to IDLE.
REQ-013 Latency: load sampled at edge N; HEX outputs change and done=1 after edge N+IN_WIDTH+1; ready=1 again after that same edge.
REQ-014 The latency in REQ-013 SHALL be identical for all values, including overflow.
REQ-015 ready SHALL be 0 in SHIFT and UPDATE; load asserted then SHALL be ignored with no effect on the conversion in progress.
REQ-016 HEX outputs SHALL hold their previous values throughout SHIFT, so the display never shows partial results.
REQ-017 Digit glyphs SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 Overflow: if the captured value > 99_999_999, UPDATE SHALL drive all eight HEX outputs to dash, 0111111.
REQ-019 The overflow flag SHALL be computed from the captured value at capture time, not from the live input.
REQ-020 A value change on the input after capture SHALL NOT affect the result.

Reset
REQ-021 If rst=1 at an edge, the FSM SHALL go to IDLE and the accumulator and counter SHALL clear, in any state.
REQ-022 rst=1 SHALL take priority over a simultaneous load.
REQ-023 On reset, ready SHALL be 1 and done SHALL be 0.
REQ-024 On reset, HEX outputs SHALL show the value 0 as defined under Configuration.
REQ-025 Reset mid-SHIFT SHALL abort the conversion with no done pulse.

Configuration
REQ-026 Macro BCD_DISPLAY_BLANK_EN, when defined, SHALL blank leading-zero digits to 1111111; HEX0 SHALL always show a digit, and an all-zero value SHALL display only HEX0=0.
REQ-027 Without BCD_DISPLAY_BLANK_EN, all eight digits SHALL always be shown, with leading zeros as 1000000.
REQ-028 Overflow dashes SHALL NOT be affected by BCD_DISPLAY_BLANK_EN.

Verification
REQ-029 Reset then idle -> ready=1, done=0; HEX0=1000000; HEX1..7 = 1000000 (macro off) or 1111111 (macro on).
REQ-030 load value=12345 -> done pulses exactly 33 cycles later; HEX4..HEX0 = 1,2,3,4,5 glyphs; HEX7..5 = 0 or blank per macro.
REQ-031 load value=99_999_999 -> all eight HEX = 0010000; load value=100_000_000 -> all eight HEX = 0111111.
REQ-032 load 42, then load 7 at cycle 5 while ready=0 -> the 7 is ignored; display shows 42; a single done pulse occurs.
REQ-033 load 555, assert rst at cycle 10 of SHIFT -> no done pulse; HEX return to reset glyphs; ready=1 on the next cycle.
REQ-034 rst=1 and load=1 at the same edge -> remain in IDLE; no done pulse follows.
